// File: rtl/pkt_send_pkg.sv
// pkt_send_pkg: shared arbiter state type and default sizing constants for the packet send scheduler
package pkt_send_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int DEF_PULSE_LEN = 3;
    localparam int DEF_ADDR_W    = 25;

endpackage

// File: rtl/pkt_send_prio.sv
// pkt_send_prio: lowest-index-first picker, one-hot grant plus any-request flag
module pkt_send_prio #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         valid
);

    // isolating the lowest set bit gives lowest-index priority
    assign grant = req & (~req + N'(1));
    assign valid = |req;

endmodule

// File: rtl/pkt_send_sched.sv
// pkt_send_sched: frame-periodic per-channel send scheduler with single-grant pulse arbiter
// optional per-channel grant counters on sent_cnt when PKT_SEND_STATS_EN is defined
module pkt_send_sched
    import pkt_send_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = 32,
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic                   clk_50_pll,
    input  logic                   main_reset,
    input  logic                   mac_inited,
    input  logic                   rx_ready,
    input  logic [CNT_W-1:0]       cfg_period,
    input  logic [N_CH*CNT_W-1:0]  cfg_offset,
    input  logic [N_CH*ADDR_W-1:0] cfg_addr,
    input  logic [N_CH-1:0]        ch_en,
    output logic [N_CH-1:0]        cmd_send,
    output logic [ADDR_W-1:0]      start_ram_addr,
    output logic [N_CH-1:0]        overrun,
    output logic                   busy
`ifdef PKT_SEND_STATS_EN
    ,
    output logic [N_CH*16-1:0]     sent_cnt
`endif
);

    arb_state_t          state;
    logic [CNT_W-1:0]    frame_cnt;
    logic [N_CH-1:0]     pending;
    logic [N_CH-1:0]     granted_oh;
    logic [N_CH-1:0]     trig;
    logic [N_CH-1:0]     pick;
    logic [N_CH-1:0]     take;
    logic [N_CH-1:0]     lost;
    logic [ADDR_W-1:0]   addr_sel;
    logic [3:0]          pcnt;
    logic                req_valid;
    logic                run;
    logic                period_ok;

    assign run       = mac_inited & rx_ready;
    assign period_ok = cfg_period >= CNT_W'(2);
    assign busy      = state != ST_IDLE;
    assign take      = (state == ST_IDLE && req_valid) ? pick : '0;
    assign lost      = trig & (pending | (busy ? granted_oh : '0));

    pkt_send_prio #(.N(N_CH)) u_prio (
        .req   (pending),
        .grant (pick),
        .valid (req_valid)
    );

    // per-channel trigger match; an offset outside the frame can never fire
    always_comb begin
        trig = '0;
        for (int i = 0; i < N_CH; i++)
            trig[i] = run && period_ok && ch_en[i]
                      && frame_cnt == cfg_offset[i*CNT_W +: CNT_W]
                      && cfg_offset[i*CNT_W +: CNT_W] < cfg_period;
    end

    // start address of the channel about to be granted
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < N_CH; i++)
            if (pick[i]) addr_sel = addr_sel | cfg_addr[i*ADDR_W +: ADDR_W];
    end

    // frame counter: runs only while the link is up, wraps at period-1 or when period shrinks below it
    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset)     frame_cnt <= '0;
        else if (!period_ok) frame_cnt <= '0;
        else if (run)       frame_cnt <= (frame_cnt >= cfg_period - CNT_W'(1)) ? '0 : frame_cnt + CNT_W'(1);
    end

    // pending requests: set by triggers, cleared on grant or channel disable; collisions become sticky overruns
    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= ((pending & ~take) | (trig & ~lost)) & ch_en;
            overrun <= overrun | lost;
        end
    end

    // arbiter: IDLE grants lowest pending, PULSE holds cmd_send for PULSE_LEN cycles, GAP separates pulses
    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            state          <= ST_IDLE;
            granted_oh     <= '0;
            cmd_send       <= '0;
            start_ram_addr <= '0;
            pcnt           <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    state          <= ST_PULSE;
                    granted_oh     <= pick;
                    cmd_send       <= pick;
                    start_ram_addr <= addr_sel;
                    pcnt           <= '0;
                end
                ST_PULSE: if (pcnt == 4'(PULSE_LEN - 1)) begin
                    state    <= ST_GAP;
                    cmd_send <= '0;
                end else begin
                    pcnt <= pcnt + 4'd1;
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PKT_SEND_STATS_EN
    // saturating count of grants per channel
    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) sent_cnt <= '0;
        else
            for (int i = 0; i < N_CH; i++)
                if (take[i] && sent_cnt[i*16 +: 16] != 16'hFFFF)
                    sent_cnt[i*16 +: 16] <= sent_cnt[i*16 +: 16] + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pkt_send_sched.sv
// tb_pkt_send_sched: scoreboard bench for pkt_send_sched; stimulus pushes expected pulses, a negedge monitor checks them
module tb_pkt_send_sched;

    logic        clk_50_pll = 1'b0;
    logic        main_reset = 1'b1;
    logic        mac_inited = 1'b0;
    logic        rx_ready   = 1'b0;
    logic [31:0] cfg_period = 32'd100;
    logic [63:0] cfg_offset = '0;
    logic [49:0] cfg_addr;
    logic [1:0]  ch_en      = 2'b00;
    logic [1:0]  cmd_send;
    logic [24:0] start_ram_addr;
    logic [1:0]  overrun;
    logic        busy;
`ifdef PKT_SEND_STATS_EN
    logic [31:0] sent_cnt;
`endif

    localparam logic [24:0] A0 = 25'h00ABCDE;
    localparam logic [24:0] A1 = 25'h1234567;

    typedef struct {
        int         cyc;
        logic [1:0] oh;
        logic [24:0] addr;
        int         len;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   t0    = 0;

    pkt_send_sched dut (
        .clk_50_pll     (clk_50_pll),
        .main_reset     (main_reset),
        .mac_inited     (mac_inited),
        .rx_ready       (rx_ready),
        .cfg_period     (cfg_period),
        .cfg_offset     (cfg_offset),
        .cfg_addr       (cfg_addr),
        .ch_en          (ch_en),
        .cmd_send       (cmd_send),
        .start_ram_addr (start_ram_addr),
        .overrun        (overrun),
        .busy           (busy)
`ifdef PKT_SEND_STATS_EN
        ,
        .sent_cnt       (sent_cnt)
`endif
    );

    always #5 clk_50_pll = ~clk_50_pll;

    always @(posedge clk_50_pll) cyc <= cyc + 1;

    // monitor: compares every pulse start, its sampled length, and one-hotness
    logic [1:0] prev    = 2'b00;
    int         run_len = 0;
    int         cur_len = 3;
    always @(negedge clk_50_pll) begin
        exp_t e;
        if (cmd_send != 2'b00 && prev == 2'b00) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse cyc=%0d cmd_send=%b addr=%h", cyc, cmd_send, start_ram_addr);
                cur_len = 3;
            end else begin
                e = q.pop_front();
                cur_len = e.len;
                if (cyc != e.cyc || cmd_send != e.oh || start_ram_addr != e.addr) begin
                    bad++;
                    $display("FAIL pulse_start got cyc=%0d oh=%b addr=%h want cyc=%0d oh=%b addr=%h",
                             cyc, cmd_send, start_ram_addr, e.cyc, e.oh, e.addr);
                end
            end
            run_len = 1;
        end else if (cmd_send != 2'b00) begin
            run_len++;
        end else if (prev != 2'b00) begin
            total++;
            if (run_len != cur_len) begin
                bad++;
                $display("FAIL pulse_len got %0d want %0d at cyc=%0d", run_len, cur_len, cyc);
            end
        end
        if ($countones(cmd_send) > 1) begin
            total++;
            bad++;
            $display("FAIL onehot cmd_send=%b at cyc=%0d", cmd_send, cyc);
        end
        prev = cmd_send;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50_pll);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got %h want %h at cyc=%0d", nm, act, want, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] oh, input logic [24:0] a, input int len);
        exp_t e;
        e.cyc = c; e.oh = oh; e.addr = a; e.len = len;
        q.push_back(e);
    endtask

    // asserts reset, checks the async reset values at once, then releases with the link up
    task automatic do_reset();
        main_reset = 1'b1;
        mac_inited = 1'b0;
        rx_ready   = 1'b0;
        #2;
        check("rst_cmd_send", 32'(cmd_send), 32'd0);
        check("rst_addr", 32'(start_ram_addr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef PKT_SEND_STATS_EN
        check("rst_sent_cnt", sent_cnt, 32'd0);
`endif
        tick(2);
        main_reset = 1'b0;
        mac_inited = 1'b1;
        rx_ready   = 1'b1;
        t0 = cyc;
    endtask

    initial begin
        cfg_addr = {A1, A0};

        // single channel, periodic
        cfg_period = 32'd100; cfg_offset = {32'd150, 32'd10}; ch_en = 2'b01;
        do_reset();
        for (int k = 0; k < 3; k++) push(t0 + 12 + 100 * k, 2'b01, A0, 3);
        tick(13);
        check("busy_in_pulse", 32'(busy), 32'd1);
        tick(207);
        check("addr_hold", 32'(start_ram_addr), 32'(A0));

        // collision: ch0 first, then ch1 after GAP and IDLE
        cfg_offset = {32'd20, 32'd20}; ch_en = 2'b11;
        do_reset();
        push(t0 + 22, 2'b01, A0, 3);
        push(t0 + 27, 2'b10, A1, 3);
        tick(40);
        check("collision_overrun", 32'(overrun), 32'd0);
        check("collision_addr", 32'(start_ram_addr), 32'(A1));

        // run gating: link drops at frame 50 during a ch1 pulse, counting freezes for 30 cycles
        cfg_offset = {32'd48, 32'd60}; ch_en = 2'b11;
        do_reset();
        push(t0 + 50, 2'b10, A1, 3);
        push(t0 + 92, 2'b01, A0, 3);
        tick(50);
        rx_ready = 1'b0;
        tick(30);
        rx_ready = 1'b1;
        tick(20);

        // overrun: triggers every 4 cycles, every other one collides with the grant
        cfg_period = 32'd4; cfg_offset = {32'd0, 32'd0}; ch_en = 2'b01;
        do_reset();
        for (int k = 0; k < 4; k++) push(t0 + 2 + 8 * k, 2'b01, A0, 3);
        tick(6);
        check("overrun_set", 32'(overrun), 32'd1);
        tick(21);
        mac_inited = 1'b0;
        tick(8);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("overrun_idle", 32'(busy), 32'd0);

        // degenerate period: nothing may fire
        cfg_period = 32'd1; cfg_offset = {32'd0, 32'd0}; ch_en = 2'b11;
        do_reset();
        tick(20);
        check("period1_busy", 32'(busy), 32'd0);

        // offset equal to period never fires, offset period-1 does
        cfg_period = 32'd100; cfg_offset = {32'd99, 32'd100}; ch_en = 2'b11;
        do_reset();
        push(t0 + 101, 2'b10, A1, 3);
        tick(110);
        check("edge_offset_overrun", 32'(overrun), 32'd0);

        // reset in the second pulse cycle, next pulse a full offset after release
        cfg_offset = {32'd0, 32'd10}; ch_en = 2'b01;
        do_reset();
        push(t0 + 12, 2'b01, A0, 1);
        tick(13);
        do_reset();
        push(t0 + 12, 2'b01, A0, 3);
        tick(20);

`ifdef PKT_SEND_STATS_EN
        // five grants on ch1
        cfg_period = 32'd10; cfg_offset = {32'd0, 32'd0}; ch_en = 2'b10;
        do_reset();
        for (int k = 0; k < 5; k++) push(t0 + 2 + 10 * k, 2'b10, A1, 3);
        tick(46);
        mac_inited = 1'b0;
        tick(4);
        check("sent_cnt", sent_cnt, {16'd5, 16'd0});
`endif

        tick(2);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
